// File: rtl/layer_stack_compositor.sv
// layer_stack_compositor: fixed-priority layer merge with background, blanking and a frame-stepped global fade engine.
module layer_stack_compositor #(
  parameter int NUM_LAYERS       = 4,
  parameter int COLOR_BITS       = 4,
  parameter int BEAM_X_BITS      = 11,
  parameter int VIEW_LEFT_X      = 0,
  parameter int VIEW_RIGHT_X     = 639,
  parameter int FADE_STEP_FRAMES = 2,
  parameter int HOLD_FRAMES      = 30,
  localparam int IW              = $clog2(NUM_LAYERS + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         frame_start,
  input  logic                                         draw,
  input  logic [BEAM_X_BITS-1:0]                       beam_x,
  input  logic [NUM_LAYERS-1:0][2:0][COLOR_BITS-1:0]   layer_color,
  input  logic [NUM_LAYERS-1:0]                        layer_transparent,
  input  logic [NUM_LAYERS-1:0]                        layer_enable,
  input  logic [2:0][COLOR_BITS-1:0]                   background_color,
  input  logic                                         fade_start,
  output logic [COLOR_BITS-1:0]                        red,
  output logic [COLOR_BITS-1:0]                        green,
  output logic [COLOR_BITS-1:0]                        blue,
  output logic [IW-1:0]                                top_layer,
  output logic                                         fade_busy,
  output logic                                         fade_black,
  output logic                                         fade_done
);
  localparam int CMAX = FADE_STEP_FRAMES > HOLD_FRAMES ? FADE_STEP_FRAMES : HOLD_FRAMES;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  typedef enum logic [1:0] {IDLE, FADE_OUT, HOLD, FADE_IN} state_t;
  state_t state, state_n;
  logic [3:0] level, level_n;
  logic [CW-1:0] cnt, cnt_n;
  logic done_n, step, hold_end, blank;
  logic [2:0][COLOR_BITS-1:0] s1_color, s1_color_n;
  logic [IW-1:0] s1_idx, s1_idx_n;

  function automatic logic [COLOR_BITS-1:0] scale(input logic [COLOR_BITS-1:0] c, input logic [3:0] l);
    logic [COLOR_BITS+4:0] p;
    p = (COLOR_BITS+5)'(c) * (COLOR_BITS+5)'({1'b0, l} + 5'd1);
    return l == 4'd0 ? '0 : COLOR_BITS'(p >> 4);
  endfunction

  // Descending scan so the lowest enabled opaque layer is the last (winning) assignment.
  always_comb begin
    blank = !draw || beam_x <= BEAM_X_BITS'(VIEW_LEFT_X) || beam_x >= BEAM_X_BITS'(VIEW_RIGHT_X);
    s1_color_n = background_color;
    s1_idx_n = IW'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (layer_enable[i] && !layer_transparent[i]) begin
        s1_color_n = layer_color[i];
        s1_idx_n = IW'(i);
      end
    if (blank) begin
      s1_color_n = '0;
      s1_idx_n = IW'(NUM_LAYERS);
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n = cnt;
    done_n = 1'b0;
    step = frame_start && cnt == CW'(FADE_STEP_FRAMES - 1);
    hold_end = HOLD_FRAMES == 0 || (frame_start && cnt == CW'(HOLD_FRAMES - 1));
    case (state)
      IDLE: begin
        level_n = 4'd15;
        cnt_n = '0;
        if (fade_start) state_n = FADE_OUT;
      end
      FADE_OUT: if (frame_start) begin
        cnt_n = step ? '0 : cnt + 1'b1;
        if (step) begin
          level_n = level - 4'd1;
          if (level == 4'd1) state_n = HOLD;
        end
      end
      HOLD: begin
        level_n = 4'd0;
        if (hold_end) begin
          state_n = FADE_IN;
          cnt_n = '0;
        end else if (frame_start) cnt_n = cnt + 1'b1;
      end
      FADE_IN: if (frame_start) begin
        cnt_n = step ? '0 : cnt + 1'b1;
        if (step) begin
          level_n = level + 4'd1;
          if (level == 4'd14) begin
            state_n = IDLE;
            done_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      level <= 4'd15;
      cnt <= '0;
      fade_busy <= 1'b0;
      fade_black <= 1'b0;
      fade_done <= 1'b0;
      s1_color <= '0;
      s1_idx <= IW'(NUM_LAYERS);
      red <= '0;
      green <= '0;
      blue <= '0;
      top_layer <= IW'(NUM_LAYERS);
    end else begin
      state <= state_n;
      level <= level_n;
      cnt <= cnt_n;
      fade_busy <= state_n != IDLE;
      fade_black <= state_n == HOLD;
      fade_done <= done_n;
      s1_color <= s1_color_n;
      s1_idx <= s1_idx_n;
      red <= scale(s1_color[0], level);
      green <= scale(s1_color[1], level);
      blue <= scale(s1_color[2], level);
      top_layer <= s1_idx;
    end
  end
endmodule

// File: tb/tb_layer_stack_compositor.sv
// tb_layer_stack_compositor: randomized bench against a frame-count based model of the compositor.
module tb_layer_stack_compositor;
  localparam int NL = 4, CB = 4, XB = 11, LX = 0, RX = 639, FSF = 2, HF = 30;
  localparam int IW = $clog2(NL + 1);
  localparam int FADE_LEN = 30 * FSF + HF;
  logic clk = 0, rst = 0, frame_start = 0, draw = 0, fade_start = 0;
  logic [XB-1:0] beam_x = '0;
  logic [NL-1:0][2:0][CB-1:0] layer_color = '0;
  logic [NL-1:0] layer_transparent = '1, layer_enable = '1;
  logic [2:0][CB-1:0] background_color = '0;
  logic [CB-1:0] red, green, blue;
  logic [IW-1:0] top_layer;
  logic fade_busy, fade_black, fade_done;
  int n_checks = 0, n_fail = 0, n_done = 0, cyc = 0;
  bit m_active = 0;
  int m_k = 0, p1_idx = NL, e_idx = NL;
  int p1_rgb[3] = '{0, 0, 0};
  int e_rgb[3] = '{0, 0, 0};
  bit e_done = 0;

  always #5 clk = ~clk;

  layer_stack_compositor #(.NUM_LAYERS(NL), .COLOR_BITS(CB), .BEAM_X_BITS(XB), .VIEW_LEFT_X(LX),
    .VIEW_RIGHT_X(RX), .FADE_STEP_FRAMES(FSF), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .draw(draw), .beam_x(beam_x),
    .layer_color(layer_color), .layer_transparent(layer_transparent), .layer_enable(layer_enable),
    .background_color(background_color), .fade_start(fade_start), .red(red), .green(green),
    .blue(blue), .top_layer(top_layer), .fade_busy(fade_busy), .fade_black(fade_black),
    .fade_done(fade_done));

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Brightness as a pure function of frames seen since the fade began.
  function automatic int model_level();
    if (!m_active) return 15;
    if (m_k < 15 * FSF) return 15 - m_k / FSF;
    if (m_k < 15 * FSF + HF) return 0;
    return (m_k - 15 * FSF - HF) / FSF;
  endfunction

  function automatic bit model_black();
    return m_active && m_k >= 15 * FSF && m_k < 15 * FSF + HF;
  endfunction

  function automatic int scale(input int c, input int l);
    return l == 0 ? 0 : (c * (l + 1)) / 16;
  endfunction

  task model_reset();
    m_active = 0;
    m_k = 0;
    p1_idx = NL;
    p1_rgb = '{0, 0, 0};
  endtask

  task tick();
    int lvl;
    @(posedge clk);
    lvl = model_level();
    for (int c = 0; c < 3; c++) e_rgb[c] = scale(p1_rgb[c], lvl);
    e_idx = p1_idx;
    if (!draw || int'(beam_x) <= LX || int'(beam_x) >= RX) begin
      p1_idx = NL;
      p1_rgb = '{0, 0, 0};
    end else begin
      p1_idx = NL;
      for (int i = NL - 1; i >= 0; i--) if (layer_enable[i] && !layer_transparent[i]) p1_idx = i;
      for (int c = 0; c < 3; c++)
        if (p1_idx == NL) p1_rgb[c] = int'(background_color[c]);
        else p1_rgb[c] = int'(layer_color[p1_idx][c]);
    end
    e_done = 0;
    if (!m_active) begin
      if (fade_start) begin
        m_active = 1;
        m_k = 0;
      end
    end else if (frame_start) begin
      m_k++;
      if (m_k == FADE_LEN) begin
        m_active = 0;
        e_done = 1;
      end
    end
    #1;
    check("red", 32'(red), e_rgb[0]);
    check("green", 32'(green), e_rgb[1]);
    check("blue", 32'(blue), e_rgb[2]);
    check("top_layer", 32'(top_layer), e_idx);
    check("fade_busy", 32'(fade_busy), 32'(m_active));
    check("fade_black", 32'(fade_black), 32'(model_black()));
    check("fade_done", 32'(fade_done), 32'(e_done));
    if (fade_done) n_done++;
    cyc++;
    frame_start = (cyc % 6 == 0);
    fade_start = 0;
  endtask

  task rand_pixel();
    draw = ($urandom % 8) != 0;
    case ($urandom % 6)
      0: beam_x = XB'(LX);
      1: beam_x = XB'(RX);
      2: beam_x = XB'(RX + 1);
      3: beam_x = XB'(LX + 1);
      default: beam_x = XB'($urandom_range(LX + 2, RX - 1));
    endcase
    layer_color = 48'({$urandom, $urandom});
    layer_transparent = NL'($urandom);
    layer_enable = NL'($urandom);
    background_color = 12'($urandom);
  endtask

  task white_pixel();
    draw = 1;
    beam_x = 11'd100;
    layer_enable = '1;
    layer_transparent = 4'b1110;
    layer_color[0] = 12'hFFF;
  endtask

  task async_reset();
    #2 rst = 1;
    #1;
    check("rst_red", 32'(red), 0);
    check("rst_top", 32'(top_layer), NL);
    check("rst_busy", 32'(fade_busy), 0);
    check("rst_black", 32'(fade_black), 0);
    check("rst_done", 32'(fade_done), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
  endtask

  initial begin
    bit pulsed;
    layer_color[0] = 12'h00F;
    layer_transparent = 4'b1110;
    draw = 1;
    beam_x = 11'd100;
    async_reset();
    repeat (3) tick();
    check("first_red", 32'(red), 15);
    layer_color = 48'h123_456_789_ABC;
    layer_transparent = 4'b0000;
    layer_enable = 4'b1110;
    repeat (3) tick();
    layer_transparent = '1;
    background_color = 12'h321;
    repeat (3) tick();
    layer_transparent = '0;
    layer_enable = '1;
    beam_x = XB'(LX);
    repeat (3) tick();
    beam_x = XB'(RX);
    repeat (3) tick();
    beam_x = 11'd200;
    draw = 0;
    repeat (3) tick();
    white_pixel();
    fade_start = 1;
    tick();
    pulsed = 0;
    for (int i = 0; i < 3000 && m_active; i++) begin
      if (!pulsed && model_black() && m_k == 15 * FSF + 5) begin
        fade_start = 1;
        pulsed = 1;
      end
      tick();
    end
    check("fade_ended", 32'(m_active), 0);
    check("done_count", n_done, 1);
    repeat (4) tick();
    for (int i = 0; i < 2500; i++) begin
      if (i % 2 == 0) rand_pixel();
      fade_start = ($urandom % 60) == 0;
      tick();
    end
    for (int i = 0; i < 3000 && m_active; i++) tick();
    check("idle_before_mid_reset", 32'(m_active), 0);
    white_pixel();
    fade_start = 1;
    tick();
    for (int i = 0; i < 3000 && !(m_active && m_k >= 15 * FSF + HF && model_level() == 8); i++) tick();
    check("reached_fade_in_8", 32'(model_level()), 8);
    n_done = 0;
    async_reset();
    repeat (4) tick();
    check("post_reset_red", 32'(red), 15);
    check("post_reset_done_count", n_done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
